// File: rtl/ftdi_stream_bridge.sv
// FT245-style asynchronous FIFO bridge: paced read/write strobes on the FTDI side,
// FWFT TX FIFO and push-only RX FIFO on the fabric side, optional round-robin arbitration.
module ftdi_stream_bridge #(
    parameter int RD_SETUP_CYC = 3,
    parameter int RD_HOLD_CYC  = 2,
    parameter int WR_SETUP_CYC = 2,
    parameter int WR_PULSE_CYC = 3,
    parameter int RECOVER_CYC  = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int ARB_MODE     = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             enable,
    inout  wire  [7:0]       FTDI_data,
    input  logic             FTDI_data_avilable,
    output logic             FTDI_pop_data,
    input  logic             FTDI_empty_for_write,
    output logic             FTDI_push_data,
    output logic [7:0]       fifo_data_out,
    output logic             fifo_push_data,
    input  logic             fifo_full,
    input  logic [7:0]       fifo_data_in,
    input  logic             fifo_data_avilable,
    output logic             fifo_pop_data,
    output logic             busy,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SETUP, S_RD_HOLD, S_WR_SETUP, S_WR_PULSE, S_RECOVER
    } state_t;

    localparam logic [3:0] L_RD_SETUP = 4'(RD_SETUP_CYC - 1);
    localparam logic [3:0] L_RD_HOLD  = 4'(RD_HOLD_CYC - 1);
    localparam logic [3:0] L_WR_SETUP = 4'(WR_SETUP_CYC - 1);
    localparam logic [3:0] L_WR_PULSE = 4'(WR_PULSE_CYC - 1);
    localparam logic [3:0] L_RECOVER  = 4'(RECOVER_CYC - 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [SYNC_STAGES-1:0] r_rxf_sync, r_txe_sync;
    logic                   r_last_rd;
    logic                   r_pop_n, r_push_n, r_oe, r_fpush, r_fpop;
    logic [7:0]             r_tx_data, r_rx_data;
    logic [CNT_W-1:0]       r_rx_count, r_tx_count;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_last, w_rd_elig, w_wr_elig, w_rd_wins, w_start_rd, w_start_wr;
    logic       w_pop_n_nxt, w_push_n_nxt, w_oe_nxt, w_fpush_nxt, w_fpop_nxt, w_tx_done;

    assign w_last    = (r_cnt == 4'd0);
    assign w_rd_elig = !r_rxf_sync[SYNC_STAGES-1] && !fifo_full && enable;
    assign w_wr_elig = !r_txe_sync[SYNC_STAGES-1] && fifo_data_avilable && enable;
    // With both sides ready, round-robin favours whichever direction did not go last.
    assign w_rd_wins = w_rd_elig && (!w_wr_elig || (ARB_MODE == 0) || !r_last_rd);

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rxf_sync <= '1;
            r_txe_sync <= '1;
            r_last_rd  <= 1'b0;
            r_pop_n    <= 1'b1;
            r_push_n   <= 1'b1;
            r_oe       <= 1'b0;
            r_fpush    <= 1'b0;
            r_fpop     <= 1'b0;
            r_tx_data  <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_count <= '0;
            r_tx_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rxf_sync <= {r_rxf_sync[SYNC_STAGES-2:0], FTDI_data_avilable};
            r_txe_sync <= {r_txe_sync[SYNC_STAGES-2:0], FTDI_empty_for_write};
            r_pop_n    <= w_pop_n_nxt;
            r_push_n   <= w_push_n_nxt;
            r_oe       <= w_oe_nxt;
            r_fpush    <= w_fpush_nxt;
            r_fpop     <= w_fpop_nxt;
            if (w_start_rd) r_last_rd <= 1'b1;
            if (w_start_wr) begin
                r_last_rd <= 1'b0;
                r_tx_data <= fifo_data_in;
            end
            if (w_fpush_nxt) begin
                r_rx_data  <= FTDI_data;
                r_rx_count <= r_rx_count + 1'b1;
            end
            if (w_tx_done) r_tx_count <= r_tx_count + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 4'd1;
        w_start_rd  = 1'b0;
        w_start_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (w_rd_wins) begin
                    w_start_rd  = 1'b1;
                    w_state_nxt = S_RD_SETUP;
                    w_cnt_nxt   = L_RD_SETUP;
                end else if (w_wr_elig) begin
                    w_start_wr  = 1'b1;
                    w_state_nxt = S_WR_SETUP;
                    w_cnt_nxt   = L_WR_SETUP;
                end
            end
            S_RD_SETUP: if (w_last) begin w_state_nxt = S_RD_HOLD;  w_cnt_nxt = L_RD_HOLD;  end
            S_RD_HOLD:  if (w_last) begin w_state_nxt = S_RECOVER;  w_cnt_nxt = L_RECOVER;  end
            S_WR_SETUP: if (w_last) begin w_state_nxt = S_WR_PULSE; w_cnt_nxt = L_WR_PULSE; end
            S_WR_PULSE: if (w_last) begin w_state_nxt = S_RECOVER;  w_cnt_nxt = L_RECOVER;  end
            S_RECOVER:  if (w_last) begin w_state_nxt = S_IDLE;     w_cnt_nxt = 4'd0;       end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Next values for the registered strobes; bus stays driven one RECOVER cycle for hold.
    always_comb begin
        w_pop_n_nxt  = !(w_state_nxt == S_RD_SETUP || w_state_nxt == S_RD_HOLD);
        w_push_n_nxt = !(w_state_nxt == S_WR_PULSE);
        w_tx_done    = (r_state == S_WR_PULSE) && w_last;
        w_oe_nxt     = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) || w_tx_done;
        w_fpush_nxt  = (r_state == S_RD_SETUP) && w_last;
        w_fpop_nxt   = w_start_wr;
    end

    assign FTDI_data      = r_oe ? r_tx_data : 8'hzz;
    assign FTDI_pop_data  = r_pop_n;
    assign FTDI_push_data = r_push_n;
    assign fifo_data_out  = r_rx_data;
    assign fifo_push_data = r_fpush;
    assign fifo_pop_data  = r_fpop;
    assign busy           = (r_state != S_IDLE);
    assign rx_count       = r_rx_count;
    assign tx_count       = r_tx_count;

endmodule

// File: tb/tb_ftdi_stream_bridge.sv
// Directed bench: table of single-transfer scenarios plus hand sequences for
// arbitration order, fifo_full back-pressure, reset mid-write and counter wrap.
module tb_ftdi_stream_bridge;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic rxf_n = 1'b1, txe_n = 1'b1, ffull = 1'b0, fdav = 1'b0;
    logic [7:0] fdin = 8'h00, rx_byte = 8'h00;

    always #5 clk = ~clk;

    wire  [7:0]  bus_a, bus_b, bus_c;
    logic        pop_a, push_a, fpush_a, fpop_a, busy_a;
    logic        pop_b, push_b, fpush_b, fpop_b, busy_b;
    logic        pop_c, push_c, fpush_c, fpop_c, busy_c;
    logic [7:0]  fdo_a, fdo_b, fdo_c;
    logic [15:0] rxc_a, txc_a, rxc_b, txc_b;
    logic [3:0]  rxc_c, txc_c;

    // FTDI chip model: drives its RX byte while the read strobe is low.
    assign bus_a = pop_a ? 8'hzz : rx_byte;
    assign bus_b = pop_b ? 8'hzz : rx_byte;
    assign bus_c = pop_c ? 8'hzz : rx_byte;

    ftdi_stream_bridge u_dut (
        .clk_pll(clk), .reset(reset), .enable(en_a), .FTDI_data(bus_a),
        .FTDI_data_avilable(rxf_n), .FTDI_pop_data(pop_a),
        .FTDI_empty_for_write(txe_n), .FTDI_push_data(push_a),
        .fifo_data_out(fdo_a), .fifo_push_data(fpush_a), .fifo_full(ffull),
        .fifo_data_in(fdin), .fifo_data_avilable(fdav), .fifo_pop_data(fpop_a),
        .busy(busy_a), .rx_count(rxc_a), .tx_count(txc_a));

    ftdi_stream_bridge #(.ARB_MODE(0)) u_prio (
        .clk_pll(clk), .reset(reset), .enable(en_b), .FTDI_data(bus_b),
        .FTDI_data_avilable(rxf_n), .FTDI_pop_data(pop_b),
        .FTDI_empty_for_write(txe_n), .FTDI_push_data(push_b),
        .fifo_data_out(fdo_b), .fifo_push_data(fpush_b), .fifo_full(ffull),
        .fifo_data_in(fdin), .fifo_data_avilable(fdav), .fifo_pop_data(fpop_b),
        .busy(busy_b), .rx_count(rxc_b), .tx_count(txc_b));

    ftdi_stream_bridge #(.CNT_W(4)) u_c4 (
        .clk_pll(clk), .reset(reset), .enable(en_c), .FTDI_data(bus_c),
        .FTDI_data_avilable(rxf_n), .FTDI_pop_data(pop_c),
        .FTDI_empty_for_write(txe_n), .FTDI_push_data(push_c),
        .fifo_data_out(fdo_c), .fifo_push_data(fpush_c), .fifo_full(ffull),
        .fifo_data_in(fdin), .fifo_data_avilable(fdav), .fifo_pop_data(fpop_c),
        .busy(busy_c), .rx_count(rxc_c), .tx_count(txc_c));

    // Running totals sampled on the falling edge; tests work with deltas.
    int t_pop = 0, t_push = 0, t_oe = 0, t_fpush = 0, t_fpop = 0, t_c4push = 0;
    logic [7:0] m_rxb = 8'h00, m_txb = 8'h00;
    byte log_a[$];
    byte log_b[$];

    always @(negedge clk) begin
        if (!pop_a) t_pop++;
        if (!push_a) begin t_push++; m_txb = bus_a; end
        if (pop_a && !(bus_a === 8'hzz)) t_oe++;
        if (fpush_a) begin t_fpush++; m_rxb = fdo_a; end
        if (fpop_a) t_fpop++;
        if (fpush_c) t_c4push++;
        if (fpush_a) log_a.push_back(8'h52);
        if (fpop_a)  log_a.push_back(8'h57);
        if (fpush_b) log_b.push_back(8'h52);
        if (fpop_b)  log_b.push_back(8'h57);
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic       en, rxf_n, txe_n, ff, fdav, drop_en;
        logic [7:0] rxb, txb;
        int         pop, push, oe, fpush, fpop;
    } vec_t;

    vec_t tv[7];

    initial begin
        int k;
        int b_pop, b_push, b_oe, b_fpush, b_fpop, b_c4;
        int exp_rx, exp_tx;
        logic [31:0] got;
        logic [31:0] exp_rr, exp_pr;

        //        en rxf txe ff fdav drop  rxb    txb   pop push oe fpush fpop
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 5, 0, 0, 1, 0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 0, 3, 6, 0, 1};
        tv[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 0, 0, 0, 0, 0};
        tv[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 0, 0, 0, 0, 0};
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 0, 0, 0, 0, 0};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 5, 0, 0, 1, 0};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 0, 3, 6, 0, 1};

        // Reset values, observed asynchronously before any clock edge matters
        #2 reset = 1'b1;
        #1;
        check("rst_pop_n",   32'(pop_a), 1);
        check("rst_push_n",  32'(push_a), 1);
        check("rst_bus_z",   32'(bus_a === 8'hzz), 1);
        check("rst_fpush",   32'(fpush_a), 0);
        check("rst_fpop",    32'(fpop_a), 0);
        check("rst_fdo",     32'(fdo_a), 0);
        check("rst_busy",    32'(busy_a), 0);
        check("rst_counts",  {rxc_a, txc_a}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Contention: both directions eligible continuously
        @(posedge clk); #1;
        rxf_n = 1'b0; txe_n = 1'b0; fdav = 1'b1; ffull = 1'b0;
        fdin = 8'h11; rx_byte = 8'h22; en_a = 1'b1; en_b = 1'b1;
        k = 0;
        while ((log_a.size() < 4 || log_b.size() < 4) && k < 150) begin
            @(negedge clk); k++;
        end
        check("contention_timeout", 32'(k < 150), 1);
        en_a = 1'b0; en_b = 1'b0; rxf_n = 1'b1; txe_n = 1'b1; fdav = 1'b0;
        repeat (20) @(posedge clk);
        exp_rr = "RWRW";
        exp_pr = "RRRR";
        got = {log_a[0], log_a[1], log_a[2], log_a[3]};
        check("order_round_robin", got, exp_rr);
        got = {log_b[0], log_b[1], log_b[2], log_b[3]};
        check("order_read_prio", got, exp_pr);

        do_reset();
        exp_rx = 0; exp_tx = 0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            en_a = tv[i].en; rxf_n = tv[i].rxf_n; txe_n = tv[i].txe_n;
            ffull = tv[i].ff; fdav = tv[i].fdav; rx_byte = tv[i].rxb; fdin = tv[i].txb;
            b_pop = t_pop; b_push = t_push; b_oe = t_oe; b_fpush = t_fpush; b_fpop = t_fpop;
            k = 0;
            while (!busy_a && k < 8) begin @(negedge clk); k++; end
            // Flags, FIFO head and (optionally) enable change after start; transfer must be unaffected
            @(posedge clk); #1;
            rxf_n = 1'b1; txe_n = 1'b1; fdav = 1'b0; fdin = ~tv[i].txb;
            if (tv[i].drop_en) en_a = 1'b0;
            repeat (16) @(posedge clk);
            #1;
            check($sformatf("v%0d_pop_low", i),   t_pop - b_pop, tv[i].pop);
            check($sformatf("v%0d_push_low", i),  t_push - b_push, tv[i].push);
            check($sformatf("v%0d_bus_drv", i),   t_oe - b_oe, tv[i].oe);
            check($sformatf("v%0d_fifo_push", i), t_fpush - b_fpush, tv[i].fpush);
            check($sformatf("v%0d_fifo_pop", i),  t_fpop - b_fpop, tv[i].fpop);
            if (tv[i].fpush != 0) check($sformatf("v%0d_rx_byte", i), 32'(m_rxb), 32'(tv[i].rxb));
            if (tv[i].push != 0)  check($sformatf("v%0d_tx_byte", i), 32'(m_txb), 32'(tv[i].txb));
            exp_rx += tv[i].fpush;
            exp_tx += tv[i].fpop;
            check($sformatf("v%0d_rx_count", i), 32'(rxc_a), exp_rx);
            check($sformatf("v%0d_tx_count", i), 32'(txc_a), exp_tx);
            check($sformatf("v%0d_idle", i), 32'(busy_a), 0);
            ffull = 1'b0;
        end

        // fifo_full holds off a pending read; release starts it promptly
        @(posedge clk); #1;
        en_a = 1'b1; ffull = 1'b1; rxf_n = 1'b0; rx_byte = 8'h6B;
        b_pop = t_pop;
        repeat (10) @(posedge clk);
        check("ff_no_pop", t_pop - b_pop, 0);
        #1 ffull = 1'b0;
        k = 0;
        while (pop_a && k < 10) begin @(negedge clk); k++; end
        check("ff_release_latency", 32'(k >= 1 && k <= 3), 1);
        @(posedge clk); #1 rxf_n = 1'b1;
        repeat (15) @(posedge clk);
        exp_rx++;
        check("ff_rx_count", 32'(rxc_a), exp_rx);
        check("ff_rx_byte", 32'(m_rxb), 32'h6B);

        // Reset during the 2nd WR_PULSE cycle
        @(posedge clk); #1;
        txe_n = 1'b0; fdav = 1'b1; fdin = 8'h96;
        k = 0;
        while (push_a && k < 20) begin @(negedge clk); k++; end
        check("wr_pulse_seen", 32'(k < 20), 1);
        @(posedge clk); #1;
        reset = 1'b1; txe_n = 1'b1; fdav = 1'b0;
        #1;
        check("rst_mid_push_n", 32'(push_a), 1);
        check("rst_mid_bus_z",  32'(bus_a === 8'hzz), 1);
        check("rst_mid_tx_cnt", 32'(txc_a), 0);
        check("rst_mid_fpop",   32'(fpop_a), 0);
        check("rst_mid_busy",   32'(busy_a), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        en_a = 1'b0;

        // 4-bit counter wraps after 16 reads
        @(posedge clk); #1;
        en_c = 1'b1; rxf_n = 1'b0; ffull = 1'b0; fdav = 1'b0;
        b_c4 = t_c4push;
        k = 0;
        while ((t_c4push - b_c4) < 17 && k < 300) begin @(negedge clk); k++; end
        en_c = 1'b0; rxf_n = 1'b1;
        check("c4_timeout", 32'(k < 300), 1);
        repeat (15) @(posedge clk);
        #1;
        check("c4_pushes", t_c4push - b_c4, 17);
        check("c4_rx_wrap", 32'(rxc_c), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
